regfile_wb_arbiter: RTL
=======================

# regfile_wb_arbiter

Shares the single write port of the 32×32 register file between two writeback sources: the ALU pipe and the load/memory unit. Issue logic reserves destination registers through a pending-write scoreboard and receives a RAW/WAW hazard flag. It sits between the EX/MEM writeback stage and the register file. It owns `RegWrite`, `Rd` and `Write_data` as a registered one-cycle write pulse.

## Interface
- `XLEN`, 32, data width
- `NREG`, 32, number of architectural registers
- `AW`, 5, register index width
- `STARVE_MAX`, 3, consecutive ALU losses before ALU gets priority (1..3)

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `alu_valid` in 1, `alu_ready` out 1, `alu_rd` in AW, `alu_data` in XLEN: ALU writeback request
- `mem_valid` in 1, `mem_ready` out 1, `mem_rd` in AW, `mem_data` in XLEN: load writeback request
- `issue_valid` in 1, `issue_rd` in AW: reserve a destination register at issue
- `chk_rs1`, `chk_rs2` in AW: source registers of the instruction being issued
- `hazard` out 1: combinational, any of rs1/rs2/issue_rd is pending
- `rf_we` out 1, `rf_rd` out AW, `rf_wdata` out XLEN: registered write port to the register file
- `pending` out NREG: scoreboard bits
- `err` out 1: sticky protocol-violation flag

## Operation
- Handshake: a transfer occurs when valid and ready are both high at a rising edge. Requesters hold rd/data stable while valid is high and ready is low.
- Ready is independent of the requester's own valid:
  - `alu_pri = (starve_cnt == STARVE_MAX)`
  - `mem_ready = !(alu_pri && alu_valid)`
  - `alu_ready = !mem_valid || alu_pri`
- At most one transfer per cycle.
- Starvation counter (2 bit):
  - increments when `alu_valid && !alu_ready`
  - clears to 0 on an ALU transfer or when `alu_valid` is 0
  - saturates at STARVE_MAX
- Winning transfer: next cycle `rf_we=1`, `rf_rd=rd`, `rf_wdata=data`. Otherwise `rf_we=0`; rd/data hold their last values.
- Register 0:
  - a transfer with rd=0 is accepted but produces `rf_we=0`
  - issue with rd=0 never sets pending
  - rs/rd of 0 never raise hazard
- Scoreboard:
  - `pending[r]` is set at the edge where `issue_valid && issue_rd==r` (r≠0)
  - it is cleared at the edge ending the `rf_we` cycle for r, so readers see the committed value
  - when set and clear hit the same r on the same edge, set wins
- Hazard: `pending[chk_rs1] | pending[chk_rs2] | pending[issue_rd]`. The issue_rd term is masked when `rf_we && rf_rd==issue_rd` (that write commits this edge).
- Violations set `err`, which holds until reset:
  - `issue_valid` while the issue_rd term of hazard is 1
  - a writeback transfer to r≠0 with `pending[r]==0`

## Timing
- Reset values: `rf_we=0`, `rf_rd=0`, `rf_wdata=0`, `pending=0`, `starve_cnt=0`, `err=0`. Consequently `hazard=0` and `mem_ready=1`. `alu_ready` is combinational: 1 while `mem_valid=0`.
- Reset mid-operation: an in-flight write is dropped (no `rf_we` pulse) and all reservations are lost.
- Latency: handshake to `rf_we` is 1 cycle. Handshake to pending-clear is 2 edges.
- Throughput: one write per cycle, with back-to-back `rf_we` allowed.
- `hazard`, `alu_ready` and `mem_ready` are combinational. All other outputs are registered.

## Structure
- Package `regfile_pkg`: `XLEN`, `NREG`, `AW` constants; `reg_idx_t`; `wb_req_t` struct {valid, rd, data}.
- Sub-module `wb_scoreboard`: pending vector with set/clear/set-wins logic, hazard compare and the issue-side err term. The arbiter and output register stay in the top module.

## Test plan
- Reset asserted asynchronously mid-cycle: all outputs take their reset values immediately, `mem_ready=1`, `alu_ready=1` with `mem_valid=0`.
- Issue rd=5. Then ALU valid, rd=5, data=0xA. Required: `alu_ready=1`; next cycle `rf_we=1`, `rf_rd=5`, `rf_wdata=0xA`; `pending[5]` drops one edge later; `hazard` for rs1=5 is 1 until then.
- Both valid every cycle, STARVE_MAX=3, distinct reserved rds. Required: MEM wins cycles 0–2, ALU wins cycle 3, counter returns to 0, MEM wins cycle 4.
- ALU transfer with rd=0, data=0xFFFF. Required: `alu_ready=1`, `rf_we` stays 0, pending unchanged. Issue rd=0 sets nothing.
- `rf_we` for rd=7 and issue rd=7 in the same cycle. Required: `hazard=0`, `pending[7]` remains 1, `err=0`.
- Issue rd=9 twice with no writeback between. Required: `hazard=1` on the second cycle; `err` rises and holds until `rst`.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and types for the register-file writeback path
package regfile_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    typedef logic [AW-1:0] reg_idx_t;

    typedef struct packed {
        logic             valid;
        reg_idx_t         rd;
        logic [XLEN-1:0]  data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_scoreboard.sv
// rtl/regfile_wb_scoreboard.sv - pending-write scoreboard with hazard detection
module wb_scoreboard #(
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    input  logic [AW-1:0]   chk_rs1,
    input  logic [AW-1:0]   chk_rs2,
    input  logic            clr_valid,
    input  logic [AW-1:0]   clr_rd,
    output logic [NREG-1:0] pending,
    output logic            hazard,
    output logic            issue_err
);

    logic [NREG-1:0] pending_nxt;
    logic            rd_term;
    logic            rd_commit;

    // Next reservation state: the committing write clears first, a new issue then sets,
    // so a same-register collision keeps the fresh reservation. Register 0 is never tracked.
    always_comb begin
        pending_nxt = pending;
        if (clr_valid) begin
            pending_nxt[clr_rd] = 1'b0;
        end
        if (issue_valid) begin
            pending_nxt[issue_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    // Reservation register; everything in flight is forgotten on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    // The destination term ignores a register whose write is committing on this edge.
    always_comb begin
        rd_commit = clr_valid && (clr_rd == issue_rd);
        rd_term   = pending[issue_rd] && !rd_commit;
        hazard    = pending[chk_rs1] || pending[chk_rs2] || rd_term;
        issue_err = issue_valid && rd_term;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - two-source writeback arbiter driving the register-file write port
module regfile_wb_arbiter #(
    parameter int XLEN       = 32,
    parameter int NREG       = 32,
    parameter int AW         = 5,
    parameter int STARVE_MAX = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [AW-1:0]   mem_rd,
    input  logic [XLEN-1:0] mem_data,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    input  logic [AW-1:0]   chk_rs1,
    input  logic [AW-1:0]   chk_rs2,
    output logic            hazard,
    output logic            rf_we,
    output logic [AW-1:0]   rf_rd,
    output logic [XLEN-1:0] rf_wdata,
    output logic [NREG-1:0] pending,
    output logic            err
);

    import regfile_pkg::*;

    localparam logic [1:0] STARVE_LIM = 2'(STARVE_MAX);

    logic     [1:0] starve_cnt;
    logic           alu_pri;
    logic           alu_fire;
    logic           mem_fire;
    logic           issue_err;
    logic           wb_err;
    wb_req_t        alu_req;
    wb_req_t        mem_req;
    wb_req_t        win_req;

    // Requests packed for a single selection path.
    always_comb begin
        alu_req = '{valid: alu_valid, rd: alu_rd, data: alu_data};
        mem_req = '{valid: mem_valid, rd: mem_rd, data: mem_data};
    end

    // Loads win by default; a starved ALU takes priority. Readies never look at their own valid,
    // and the two fire terms are mutually exclusive by construction.
    always_comb begin
        alu_pri   = (starve_cnt == STARVE_LIM);
        mem_ready = !(alu_pri && alu_valid);
        alu_ready = !mem_valid || alu_pri;
        alu_fire  = alu_valid && alu_ready;
        mem_fire  = mem_valid && mem_ready;
    end

    // Selected transfer for this cycle; valid doubles as the handshake flag.
    always_comb begin
        win_req = '0;
        if (alu_fire) begin
            win_req = alu_req;
        end else if (mem_fire) begin
            win_req = mem_req;
        end
        win_req.valid = alu_fire || mem_fire;
    end

    // A write to a register nobody reserved means issue and writeback disagree.
    always_comb begin
        wb_err = win_req.valid && (win_req.rd != '0) && !pending[win_req.rd];
    end

    // Count consecutive ALU losses; any ALU win or idle ALU starts over.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= 2'd0;
        end else if (!alu_valid || alu_fire) begin
            starve_cnt <= 2'd0;
        end else if (starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + 2'd1;
        end
    end

    // One-cycle write pulse; register 0 writes are swallowed, index/data hold when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= win_req.valid && (win_req.rd != '0);
            if (win_req.valid) begin
                rf_rd    <= win_req.rd;
                rf_wdata <= win_req.data;
            end
        end
    end

    // Sticky protocol-violation flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (issue_err || wb_err) begin
            err <= 1'b1;
        end
    end

    wb_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .chk_rs1     (chk_rs1),
        .chk_rs2     (chk_rs2),
        .clr_valid   (rf_we),
        .clr_rd      (rf_rd),
        .pending     (pending),
        .hazard      (hazard),
        .issue_err   (issue_err)
    );

endmodule
